// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: 2-FF sync, debounce, press/release/long-press pulses.
// Defining BUTTON_COND_REPEAT_EN builds the auto-repeat generator; otherwise o_repeat is 0.
module button_conditioner #(
  parameter int NUM_BUTTONS       = 4,
  parameter int ACTIVE_LOW        = 1,
  parameter int DEBOUNCE_CYCLES   = 500_000,
  parameter int LONG_PRESS_CYCLES = 50_000_000,
  parameter int REPEAT_CYCLES     = 10_000_000
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [NUM_BUTTONS-1:0] i_button,
  output logic [NUM_BUTTONS-1:0] o_state,
  output logic [NUM_BUTTONS-1:0] o_down,
  output logic [NUM_BUTTONS-1:0] o_up,
  output logic [NUM_BUTTONS-1:0] o_long,
  output logic [NUM_BUTTONS-1:0] o_long_held,
  output logic [NUM_BUTTONS-1:0] o_repeat
);

  localparam int MAX_DL  = (DEBOUNCE_CYCLES > LONG_PRESS_CYCLES) ? DEBOUNCE_CYCLES : LONG_PRESS_CYCLES;
  localparam int MAX_CYC = (MAX_DL > REPEAT_CYCLES) ? MAX_DL : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] DEB_TH  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LONG_TH = CNT_W'(LONG_PRESS_CYCLES);
  localparam logic             DEB_ONE = (DEBOUNCE_CYCLES == 1);
  localparam logic             ACT_LOW = (ACTIVE_LOW != 0);

  typedef enum logic [2:0] {IDLE, PRESS_WAIT, PRESSED, LONG, RELEASE_WAIT} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
    logic             sync_p0, sync_p1;
    logic             p;
    state_t           state;
    logic [CNT_W-1:0] deb_cnt, hold_cnt;
    logic [CNT_W-1:0] deb_nxt, hold_nxt;
    logic             from_long;
    logic             state_lvl, down_pls, up_pls, long_pls, held_lvl;

    // sync_p1 carries the pin level; released level is the idle value of the pin
    assign p        = sync_p1 ^ ACT_LOW;
    assign deb_nxt  = sat_inc(deb_cnt);
    assign hold_nxt = sat_inc(hold_cnt);

`ifdef BUTTON_COND_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_TH = CNT_W'(REPEAT_CYCLES);
    logic [CNT_W-1:0] rep_cnt, rep_nxt;
    logic             rep_pls;
    assign rep_nxt     = sat_inc(rep_cnt);
    assign o_repeat[g] = rep_pls;
`else
    assign o_repeat[g] = 1'b0;
`endif

    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        sync_p0   <= ACT_LOW;
        sync_p1   <= ACT_LOW;
        state     <= IDLE;
        deb_cnt   <= '0;
        hold_cnt  <= '0;
        from_long <= 1'b0;
        state_lvl <= 1'b0;
        down_pls  <= 1'b0;
        up_pls    <= 1'b0;
        long_pls  <= 1'b0;
        held_lvl  <= 1'b0;
`ifdef BUTTON_COND_REPEAT_EN
        rep_cnt   <= '0;
        rep_pls   <= 1'b0;
`endif
      end else begin
        sync_p0  <= i_button[g];
        sync_p1  <= sync_p0;
        down_pls <= 1'b0;
        up_pls   <= 1'b0;
        long_pls <= 1'b0;
`ifdef BUTTON_COND_REPEAT_EN
        rep_pls  <= 1'b0;
`endif
        case (state)
          IDLE: begin
            hold_cnt  <= '0;
            from_long <= 1'b0;
`ifdef BUTTON_COND_REPEAT_EN
            rep_cnt   <= '0;
`endif
            if (p && DEB_ONE) begin
              state     <= PRESSED;
              down_pls  <= 1'b1;
              state_lvl <= 1'b1;
              deb_cnt   <= '0;
            end else if (p) begin
              state   <= PRESS_WAIT;
              deb_cnt <= CNT_W'(1);
            end else begin
              deb_cnt <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!p) begin
              state   <= IDLE;
              deb_cnt <= '0;
            end else if (deb_nxt >= DEB_TH) begin
              state     <= PRESSED;
              down_pls  <= 1'b1;
              state_lvl <= 1'b1;
              hold_cnt  <= '0;
              deb_cnt   <= '0;
            end else begin
              deb_cnt <= deb_nxt;
            end
          end
          PRESSED: begin
            if (!p && DEB_ONE) begin
              state     <= IDLE;
              up_pls    <= 1'b1;
              state_lvl <= 1'b0;
              held_lvl  <= 1'b0;
            end else if (!p) begin
              state     <= RELEASE_WAIT;
              deb_cnt   <= CNT_W'(1);
              from_long <= 1'b0;
            end else if (hold_nxt >= LONG_TH) begin
              state    <= LONG;
              long_pls <= 1'b1;
              held_lvl <= 1'b1;
              hold_cnt <= hold_nxt;
`ifdef BUTTON_COND_REPEAT_EN
              rep_cnt  <= '0;
`endif
            end else begin
              hold_cnt <= hold_nxt;
            end
          end
          LONG: begin
            if (!p && DEB_ONE) begin
              state     <= IDLE;
              up_pls    <= 1'b1;
              state_lvl <= 1'b0;
              held_lvl  <= 1'b0;
            end else if (!p) begin
              state     <= RELEASE_WAIT;
              deb_cnt   <= CNT_W'(1);
              from_long <= 1'b1;
            end else begin
`ifdef BUTTON_COND_REPEAT_EN
              if (rep_nxt >= REP_TH) begin
                rep_pls <= 1'b1;
                rep_cnt <= '0;
              end else begin
                rep_cnt <= rep_nxt;
              end
`endif
            end
          end
          RELEASE_WAIT: begin
            // a bounce back to pressed resumes the press without new pulses
            if (p) begin
              state   <= from_long ? LONG : PRESSED;
              deb_cnt <= '0;
            end else if (deb_nxt >= DEB_TH) begin
              state     <= IDLE;
              up_pls    <= 1'b1;
              state_lvl <= 1'b0;
              held_lvl  <= 1'b0;
              deb_cnt   <= '0;
            end else begin
              deb_cnt <= deb_nxt;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign o_state[g]     = state_lvl;
    assign o_down[g]      = down_pls;
    assign o_up[g]        = up_pls;
    assign o_long[g]      = long_pls;
    assign o_long_held[g] = held_lvl;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: directed presses, expected pulse events queued by cycle.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'hF;
  logic [3:0] o_state, o_down, o_up, o_long, o_long_held, o_repeat;

  int cyc      = 0;
  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int         cyc;
    logic [3:0] down;
    logic [3:0] up;
    logic [3:0] lng;
    logic [3:0] rep;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;

  button_conditioner #(
    .NUM_BUTTONS      (4),
    .ACTIVE_LOW       (1),
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(20),
    .REPEAT_CYCLES    (6)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_button   (btn),
    .o_state    (o_state),
    .o_down     (o_down),
    .o_up       (o_up),
    .o_long     (o_long),
    .o_long_held(o_long_held),
    .o_repeat   (o_repeat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // Insert an expected pulse event in cycle order, merging events of the same cycle.
  task automatic expect_ev(input int c, input logic [3:0] d, input logic [3:0] u,
                           input logic [3:0] l, input logic [3:0] r);
    ev_t ev;
    int  idx;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].cyc == c) begin
        exp_q[i].down = exp_q[i].down | d;
        exp_q[i].up   = exp_q[i].up | u;
        exp_q[i].lng  = exp_q[i].lng | l;
        exp_q[i].rep  = exp_q[i].rep | r;
        return;
      end
    end
    idx = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].cyc > c) begin
        idx = i;
        break;
      end
    end
    ev.cyc = c; ev.down = d; ev.up = u; ev.lng = l; ev.rep = r;
    exp_q.insert(idx, ev);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: cycle=%0d got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: any pulse output is matched against the head of the expected queue.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      n_err++;
      $display("FAIL missed_event: expected at cycle=%0d down=%b up=%b long=%b rep=%b, pulse missing",
               mon_e.cyc, mon_e.down, mon_e.up, mon_e.lng, mon_e.rep);
    end
    if ((o_down | o_up | o_long | o_repeat) != 4'b0) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: cycle=%0d down=%b up=%b long=%b rep=%b, none expected",
                 cyc, o_down, o_up, o_long, o_repeat);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc || mon_e.down !== o_down || mon_e.up !== o_up ||
            mon_e.lng !== o_long || mon_e.rep !== o_repeat) begin
          n_err++;
          $display("FAIL pulse_event: got cycle=%0d down=%b up=%b long=%b rep=%b expected cycle=%0d down=%b up=%b long=%b rep=%b",
                   cyc, o_down, o_up, o_long, o_repeat,
                   mon_e.cyc, mon_e.down, mon_e.up, mon_e.lng, mon_e.rep);
        end
      end
    end
  end

  initial begin
    int c;

    // reset state
    step(3);
    chk("reset_state", o_state, 4'b0000);
    chk("reset_held", o_long_held, 4'b0000);
    chk("reset_pulses", o_down | o_up | o_long | o_repeat, 4'b0000);
    rst = 1'b0;
    step(3);

    // clean press and release on channel 0
    c = cyc;
    btn[0] = 1'b0;
    expect_ev(c + 6, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    step(5);
    chk("t1_state_before_down", o_state, 4'b0000);
    step(1);
    chk("t1_state_pressed", o_state, 4'b0001);
    step(4);
    btn[0] = 1'b1;
    expect_ev(c + 16, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    step(5);
    chk("t1_state_before_up", o_state, 4'b0001);
    step(1);
    chk("t1_state_released", o_state, 4'b0000);
    step(4);

    // bounce on channel 1: 3-cycle segments never reach the debounce count
    c = cyc;
    for (int k = 0; k < 10; k++) begin
      btn[1] = k[0];
      step(3);
    end
    chk("t2_state_during_bounce", o_state, 4'b0000);
    btn[1] = 1'b0;
    expect_ev(c + 36, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    step(6);
    chk("t2_state_pressed", o_state, 4'b0010);
    step(4);
    btn[1] = 1'b1;
    expect_ev(c + 46, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    step(6);
    chk("t2_state_released", o_state, 4'b0000);
    step(4);

    // long press on channel 0, held 60 cycles
    c = cyc;
    btn[0] = 1'b0;
    expect_ev(c + 6, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    expect_ev(c + 26, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
`ifdef BUTTON_COND_REPEAT_EN
    for (int k = 1; k <= 6; k++) expect_ev(c + 26 + 6 * k, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
`endif
    step(25);
    chk("t3_held_before_long", o_long_held, 4'b0000);
    step(1);
    chk("t3_held_at_long", o_long_held, 4'b0001);
    step(34);
    btn[0] = 1'b1;
    expect_ev(c + 66, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    step(5);
    chk("t3_held_before_up", o_long_held, 4'b0001);
    step(1);
    chk("t3_held_after_up", o_long_held, 4'b0000);
    chk("t3_state_after_up", o_state, 4'b0000);
    step(4);

    // 2-cycle release glitch while in long press
    c = cyc;
    btn[0] = 1'b0;
    expect_ev(c + 6, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    expect_ev(c + 26, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
`ifdef BUTTON_COND_REPEAT_EN
    expect_ev(c + 32, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    expect_ev(c + 41, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    expect_ev(c + 47, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
`endif
    step(30);
    btn[0] = 1'b1;
    step(2);
    btn[0] = 1'b0;
    step(2);
    chk("t4_held_in_glitch", o_long_held, 4'b0001);
    step(6);
    chk("t4_held_after_glitch", o_long_held, 4'b0001);
    chk("t4_state_after_glitch", o_state, 4'b0001);
    step(10);
    btn[0] = 1'b1;
    expect_ev(c + 56, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    step(6);
    chk("t4_held_after_up", o_long_held, 4'b0000);
    step(4);

    // reset pulse while channel 0 is in long press and still held
    c = cyc;
    btn[0] = 1'b0;
    expect_ev(c + 6, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    expect_ev(c + 26, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    step(30);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t5_state_after_reset", o_state, 4'b0000);
    chk("t5_held_after_reset", o_long_held, 4'b0000);
    chk("t5_pulses_after_reset", o_down | o_up | o_long | o_repeat, 4'b0000);
    expect_ev(c + 37, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    step(6);
    chk("t5_state_fresh_press", o_state, 4'b0001);
    step(3);
    btn[0] = 1'b1;
    expect_ev(c + 46, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    step(6);
    chk("t5_state_released", o_state, 4'b0000);
    step(4);

    // channels 0 and 3 pressed and released in the same cycle
    c = cyc;
    btn[0] = 1'b0;
    btn[3] = 1'b0;
    expect_ev(c + 6, 4'b1001, 4'b0000, 4'b0000, 4'b0000);
    step(6);
    chk("t6_state_pressed", o_state, 4'b1001);
    step(4);
    btn[0] = 1'b1;
    btn[3] = 1'b1;
    expect_ev(c + 16, 4'b0000, 4'b1001, 4'b0000, 4'b0000);
    step(6);
    chk("t6_state_released", o_state, 4'b0000);

    step(10);
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      n_err++;
      $display("FAIL missed_event: expected at cycle=%0d down=%b up=%b long=%b rep=%b, pulse missing",
               mon_e.cyc, mon_e.down, mon_e.up, mon_e.lng, mon_e.rep);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
